// File: rtl/phase_sweep_scheduler.sv
// Steps the DDS phase increment through a linear sweep, holding a stretched
// valid strobe per point and an optional dwell gap before the next point.
module phase_sweep_scheduler #(
    parameter int          PHASE_INC_WIDTH = 27,
    parameter int          VALID_CYCLES    = 16,
    parameter int          DWELL_WIDTH     = 24,
    parameter int          COUNT_WIDTH     = 16,
    parameter int unsigned RESET_PHASE_INC = 8388608
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [PHASE_INC_WIDTH-1:0] cfg_start,
    input  logic [PHASE_INC_WIDTH-1:0] cfg_step,
    input  logic [COUNT_WIDTH-1:0]     cfg_count,
    input  logic [DWELL_WIDTH-1:0]     cfg_dwell,
    input  logic                       start,
    input  logic                       abort,
    output logic [PHASE_INC_WIDTH-1:0] phase_inc,
    output logic                       phase_inc_valid,
    output logic                       busy,
    output logic                       done,
    output logic [COUNT_WIDTH-1:0]     point_index
);

    localparam int VCW = $clog2(VALID_CYCLES + 1);
    localparam logic [VCW-1:0] VALID_LAST = VCW'(VALID_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STROBE, DWELL, DONE} state_t;

    state_t                     state;
    logic [PHASE_INC_WIDTH-1:0] step_q;
    logic [COUNT_WIDTH-1:0]     last_index_q;
    logic [DWELL_WIDTH-1:0]     dwell_q;
    logic [DWELL_WIDTH-1:0]     dwell_cnt;
    logic [VCW-1:0]             valid_cnt;
    logic                       point_end;
    logic                       more_points;

    // A point ends on its last dwell cycle, or on its last strobe cycle when dwell is zero.
    assign point_end = (state == STROBE && valid_cnt == VALID_LAST && dwell_q == '0) ||
                       (state == DWELL && dwell_cnt == dwell_q - DWELL_WIDTH'(1));
    assign more_points = (point_index != last_index_q);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= IDLE;
            phase_inc       <= PHASE_INC_WIDTH'(RESET_PHASE_INC);
            phase_inc_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            point_index     <= '0;
            step_q          <= '0;
            last_index_q    <= '0;
            dwell_q         <= '0;
            dwell_cnt       <= '0;
            valid_cnt       <= '0;
        end else if (abort && state != IDLE) begin
            state           <= IDLE;
            phase_inc_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else if (point_end) begin
            valid_cnt <= '0;
            dwell_cnt <= '0;
            if (more_points) begin
                phase_inc       <= phase_inc + step_q;
                point_index     <= point_index + 1'b1;
                phase_inc_valid <= 1'b1;
                state           <= STROBE;
            end else begin
                phase_inc_valid <= 1'b0;
                done            <= 1'b1;
                state           <= DONE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        busy      <= 1'b1;
                        valid_cnt <= '0;
                        dwell_cnt <= '0;
                        if (cfg_count != '0) begin
                            step_q          <= cfg_step;
                            last_index_q    <= cfg_count - 1'b1;
                            dwell_q         <= cfg_dwell;
                            phase_inc       <= cfg_start;
                            point_index     <= '0;
                            phase_inc_valid <= 1'b1;
                            state           <= STROBE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                STROBE: begin
                    if (valid_cnt == VALID_LAST) begin
                        phase_inc_valid <= 1'b0;
                        state           <= DWELL;
                    end else begin
                        valid_cnt <= valid_cnt + 1'b1;
                    end
                end
                DWELL: begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_sweep_scheduler.sv
// Scoreboard bench: stimulus queues expected points/done pulses, a monitor
// pops and compares them whenever the scheduler presents a new point or done.
module tb_phase_sweep_scheduler;

    localparam int PW = 27;
    localparam int CW = 16;
    localparam int DW = 24;
    localparam int VC = 16;
    localparam logic [PW-1:0] RST_PHASE = 27'd8388608;
    localparam logic [PW-1:0] MINUS_100 = 27'(134217728 - 100);
    localparam logic [PW-1:0] WRAPPED   = 27'(134217728 - 50);

    typedef struct {
        bit            is_done;
        logic [PW-1:0] phase;
        logic [CW-1:0] idx;
        int            gap;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PW-1:0] cfg_start = '0;
    logic [PW-1:0] cfg_step = '0;
    logic [CW-1:0] cfg_count = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] phase_inc;
    logic          phase_inc_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] point_index;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    phase_sweep_scheduler dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cfg_start       (cfg_start),
        .cfg_step        (cfg_step),
        .cfg_count       (cfg_count),
        .cfg_dwell       (cfg_dwell),
        .start           (start),
        .abort           (abort),
        .phase_inc       (phase_inc),
        .phase_inc_valid (phase_inc_valid),
        .busy            (busy),
        .done            (done),
        .point_index     (point_index)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pushPoint(input logic [PW-1:0] phase, input logic [CW-1:0] idx, input int gap);
        exp_t e;
        e.is_done = 1'b0;
        e.phase   = phase;
        e.idx     = idx;
        e.gap     = gap;
        exp_q.push_back(e);
    endtask

    task automatic pushDone(input logic [PW-1:0] phase, input int gap);
        exp_t e;
        e.is_done = 1'b1;
        e.phase   = phase;
        e.idx     = '0;
        e.gap     = gap;
        exp_q.push_back(e);
    endtask

    // Basic sweep: 1000/1100/1200, 16 valid + 4 dwell per point.
    task automatic pushBasic(input int first_gap);
        pushPoint(27'd1000, 16'd0, first_gap);
        pushPoint(27'd1100, 16'd1, 20);
        pushPoint(27'd1200, 16'd2, 20);
        pushDone(27'd1200, 20);
    endtask

    task automatic applyStimulus(input logic [PW-1:0] s, input logic [PW-1:0] st,
                                 input logic [CW-1:0] n, input logic [DW-1:0] d);
        cfg_start = s;
        cfg_step  = st;
        cfg_count = n;
        cfg_dwell = d;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 300 && busy; i++) tick();
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic monitorLoop();
        int            cyc = 0;
        int            last_evt = 0;
        int            vlen = 0;
        bit            in_point = 1'b0;
        bit            new_point;
        logic          prev_valid = 1'b0;
        logic [PW-1:0] prev_phase = '0;
        logic [CW-1:0] prev_idx = '0;
        exp_t          e;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn || abort) begin
                in_point = 1'b0;
            end else begin
                new_point = phase_inc_valid &&
                            (!prev_valid || phase_inc != prev_phase || point_index != prev_idx);
                if (in_point && phase_inc_valid && !new_point) begin
                    vlen++;
                end else if (in_point) begin
                    checkOutput("strobe_len", vlen, VC);
                    in_point = 1'b0;
                end
                if (new_point) begin
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_point: got phase %0d index %0d, expected none", phase_inc, point_index);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("point_phase", 32'(phase_inc), 32'(e.phase));
                        checkOutput("point_index", 32'(point_index), 32'(e.idx));
                        if (e.gap >= 0) checkOutput("point_gap", cyc - last_evt, e.gap);
                    end
                    last_evt = cyc;
                    in_point = 1'b1;
                    vlen     = 1;
                end
                if (done) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got done=1, expected 0");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("done_phase", 32'(phase_inc), 32'(e.phase));
                        checkOutput("done_busy", {31'd0, busy}, 32'd1);
                        checkOutput("done_valid", {31'd0, phase_inc_valid}, 32'd0);
                        if (e.gap >= 0) checkOutput("done_gap", cyc - last_evt, e.gap);
                    end
                    last_evt = cyc;
                end
            end
            prev_valid = phase_inc_valid;
            prev_phase = phase_inc;
            prev_idx   = point_index;
        end
    endtask

    task automatic runTests();
        tick();
        tick();
        aresetn = 1'b1;
        checkOutput("reset_phase", 32'(phase_inc), 32'(RST_PHASE));
        checkOutput("reset_valid", {31'd0, phase_inc_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_index", 32'(point_index), 32'd0);

        // Zero-point sweep: busy and done together, phase untouched.
        pushDone(RST_PHASE, -1);
        applyStimulus(27'd777, 27'd1, 16'd0, 24'd3);
        checkOutput("count0_busy", {31'd0, busy}, 32'd1);
        checkOutput("count0_done", {31'd0, done}, 32'd1);
        tick();
        tick();
        checkOutput("count0_idle", {31'd0, busy}, 32'd0);
        checkOutput("count0_phase", 32'(phase_inc), 32'(RST_PHASE));
        checkOutput("count0_queue", exp_q.size(), 0);

        // Basic sweep, with cfg scrambled after the latch.
        pushBasic(-1);
        applyStimulus(27'd1000, 27'd100, 16'd3, 24'd4);
        checkOutput("basic_first_phase", 32'(phase_inc), 32'd1000);
        cfg_start = 27'd999;
        cfg_step  = 27'd5;
        cfg_count = 16'd9;
        cfg_dwell = 24'd1;
        waitIdle("basic_idle");
        checkOutput("basic_hold_phase", 32'(phase_inc), 32'd1200);
        checkOutput("basic_queue", exp_q.size(), 0);

        // Negative step wrapping below zero, no dwell.
        pushPoint(27'd50, 16'd0, -1);
        pushPoint(WRAPPED, 16'd1, 16);
        pushDone(WRAPPED, 16);
        applyStimulus(27'd50, MINUS_100, 16'd2, 24'd0);
        waitIdle("wrap_idle");
        checkOutput("wrap_queue", exp_q.size(), 0);

        // Abort during the dwell of point 1.
        pushPoint(27'd1000, 16'd0, -1);
        pushPoint(27'd1100, 16'd1, 20);
        applyStimulus(27'd1000, 27'd100, 16'd3, 24'd4);
        for (int i = 0; i < 200 && !(point_index == 16'd1 && !phase_inc_valid && busy); i++) tick();
        checkOutput("abort_reach_dwell", {31'd0, (point_index == 16'd1 && !phase_inc_valid && busy)}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_valid", {31'd0, phase_inc_valid}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_phase", 32'(phase_inc), 32'd1100);
        tick();
        tick();
        checkOutput("abort_queue", exp_q.size(), 0);
        pushBasic(-1);
        applyStimulus(27'd1000, 27'd100, 16'd3, 24'd4);
        waitIdle("after_abort_idle");
        checkOutput("after_abort_queue", exp_q.size(), 0);

        // Start held high: ignored while busy, re-accepted right after DONE.
        pushBasic(-1);
        pushBasic(2);
        cfg_start = 27'd1000;
        cfg_step  = 27'd100;
        cfg_count = 16'd3;
        cfg_dwell = 24'd4;
        start     = 1'b1;
        tick();
        for (int i = 0; i < 200 && !done; i++) tick();
        checkOutput("held_first_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 10 && !phase_inc_valid; i++) tick();
        checkOutput("held_restart", {31'd0, phase_inc_valid}, 32'd1);
        start = 1'b0;
        waitIdle("held_idle");
        checkOutput("held_queue", exp_q.size(), 0);

        // Reset in the middle of a strobe.
        pushPoint(27'd1000, 16'd0, -1);
        applyStimulus(27'd1000, 27'd100, 16'd3, 24'd4);
        tick();
        tick();
        aresetn = 1'b0;
        tick();
        checkOutput("midreset_phase", 32'(phase_inc), 32'(RST_PHASE));
        checkOutput("midreset_valid", {31'd0, phase_inc_valid}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_index", 32'(point_index), 32'd0);
        aresetn = 1'b1;
        checkOutput("midreset_queue", exp_q.size(), 0);

        // Start and abort together in IDLE: stays idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        checkOutput("start_abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("start_abort_valid", {31'd0, phase_inc_valid}, 32'd0);
        tick();
        checkOutput("start_abort_busy2", {31'd0, busy}, 32'd0);
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        checkOutput("final_queue", exp_q.size(), 0);
    endtask

    initial begin
        fork
            monitorLoop();
            runTests();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/phase_sweep_scheduler.md
# phase_sweep_scheduler

Sequences the DDS phase increment through a linear frequency sweep, so the MCU does not have to issue one SET_PHASE_INC command per frequency point. It sits between the MCU command dispatcher and the DDS phase-increment input. Configuration is latched on a start pulse. The block then steps the phase increment, emitting a stretched valid strobe for each point and dwelling between points. It reports busy and done, and an abort returns it to idle at any time.

## Interface
- PHASE_INC_WIDTH, 27, width of phase increment
- VALID_CYCLES, 16, aclk cycles phase_inc_valid stays high per point (≥1)
- DWELL_WIDTH, 24, width of dwell counter
- COUNT_WIDTH, 16, width of point counter
- RESET_PHASE_INC, 8388608, phase_inc value after reset (1 MHz)
- aclk  in  1  system clock; all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- cfg_start  in  PHASE_INC_WIDTH  first phase increment
- cfg_step  in  PHASE_INC_WIDTH  signed two's-complement step added per point
- cfg_count  in  COUNT_WIDTH  number of points in sweep
- cfg_dwell  in  DWELL_WIDTH  extra idle cycles after each strobe
- start  in  1  level; sampled only in IDLE
- abort  in  1  level; highest priority after reset
- phase_inc  out  PHASE_INC_WIDTH  increment to DDS
- phase_inc_valid  out  1  update strobe to DDS
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal completion
- point_index  out  COUNT_WIDTH  index of point currently presented, 0-based

## Operation
- States: IDLE, STROBE, DWELL, DONE.
- Reset (aresetn=0 at an edge): state=IDLE, phase_inc=RESET_PHASE_INC, phase_inc_valid=0, busy=0, done=0, point_index=0. All counters are cleared.
- IDLE:
  - start=1 and cfg_count≠0: latch step, count, and dwell. Load phase_inc=cfg_start, point_index=0, valid=1. Go to STROBE.
  - start=1 and cfg_count=0: go to DONE without touching phase_inc.
- STROBE: valid stays high for exactly VALID_CYCLES cycles, then goes to DWELL.
- DWELL: valid=0 for the latched dwell cycles. A dwell of 0 skips DWELL entirely.
  - At the end of DWELL, if more points remain: phase_inc += step, point_index += 1, valid=1, go to STROBE.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE. phase_inc holds its last value.
- Arithmetic: phase_inc update is modulo 2^PHASE_INC_WIDTH. Wrap-around is silent; there is no saturation.
- abort=1 in any non-IDLE state: next edge goes to IDLE, valid=0, done not pulsed, phase_inc holds its current value.
  - abort in IDLE has no effect, and it overrides a simultaneous start.
- start while busy is ignored. cfg_* changes after the latch have no effect on the running sweep.
- A single-point sweep (cfg_count=1) presents cfg_start only, then goes to DONE.

## Timing
- Edge on which start is sampled in IDLE → next cycle: phase_inc=cfg_start, valid=1, busy=1.
- Point period = VALID_CYCLES + dwell cycles. The first valid cycle of point k+1 follows the last dwell cycle of point k with no gap.
- phase_inc changes only on the cycle valid rises, and is stable for the whole strobe and dwell.
- With cfg_count=N≥1:
  - done asserts on the cycle after the last dwell cycle of point N−1, or after its last strobe cycle when dwell=0.
  - busy is high from the first valid cycle through the done cycle inclusive, then falls.
- cfg_count=0: busy=1 and done=1 together, one cycle after start, for one cycle. valid never asserts.
- Reset mid-sweep: on the next edge all outputs take their reset values, including phase_inc=RESET_PHASE_INC.

## Test plan
- Basic sweep:
  - Stimulus: cfg_start=1000, cfg_step=100, cfg_count=3, cfg_dwell=4, VALID_CYCLES=16, start pulse.
  - Response: phase_inc 1000/1100/1200, each with 16 valid cycles then 4 idle cycles (period 20), point_index 0/1/2. done is one cycle after the last dwell cycle, and phase_inc holds 1200.
- Negative step with wrap:
  - Stimulus: cfg_start=50, cfg_step=−100 (2^27−100), cfg_count=2, dwell=0.
  - Response: phase_inc 50, then 2^27−50. Valid is high for 32 contiguous cycles, split 16/16.
- cfg_count=0: start → busy and done pulse together for one cycle, valid stays 0, phase_inc unchanged (8388608 after reset).
- Abort mid-DWELL of point 1 in the basic sweep → next cycle IDLE, busy=0, valid=0, no done, phase_inc=1100. A subsequent start runs a full sweep.
- start held high throughout the basic sweep → no restart while busy. A new sweep begins the cycle after DONE returns to IDLE, and start on that cycle is accepted.
- aresetn=0 during STROBE → next cycle phase_inc=8388608, valid=0, busy=0, point_index=0. Simultaneous start and abort in IDLE → remains IDLE.
